// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the pipeline sequencer:
//                state encodings, register-index width and per-stage
//                enable/flush bundles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    // Architectural register index width (32 GPRs)
    localparam int REG_IDX_WIDTH = 5;

    // Sequencer state encoding; also driven out on ctrl_state for debug
    localparam int PIPE_ST_WIDTH = 2;

    typedef enum logic [PIPE_ST_WIDTH-1:0] {
        PIPE_ST_RUN      = 2'd0,
        PIPE_ST_MEM_WAIT = 2'd1,
        PIPE_ST_TRAP     = 2'd2
    } pipe_st_e;

    // Write enables for the PC and the four pipeline registers
    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } pipe_wen_t;

    // Bubble-load requests for the four pipeline registers
    typedef struct packed {
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } pipe_flush_t;

    // True when a source operand is read and names the given destination
    function automatic logic src_hits_rd(
        input logic [REG_IDX_WIDTH-1:0] src_idx,
        input logic                     src_ren,
        input logic [REG_IDX_WIDTH-1:0] rd_idx
    );
        return src_ren && (src_idx == rd_idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_det.sv
// ============================================================================
//  Module      : pipe_hazard_det
//  Description : Combinational load-use hazard detector. Flags when the
//                instruction in EX is a load writing a non-zero rd that the
//                instruction in ID reads through rs1 or rs2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_det
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_WIDTH-1:0] id_rs1_idx,
    input  logic                     id_rs1_ren,
    input  logic [REG_IDX_WIDTH-1:0] id_rs2_idx,
    input  logic                     id_rs2_ren,
    input  logic [REG_IDX_WIDTH-1:0] id_ex_rd_idx,
    input  logic                     id_ex_rd_en,
    input  logic                     id_ex_is_load,
    output logic                     lu_hazard
);

    logic w_load_writes_rd;
    logic w_src_hit;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard
    assign w_load_writes_rd = id_ex_is_load && id_ex_rd_en && (id_ex_rd_idx != '0);

    // Either enabled source operand matching the load destination
    assign w_src_hit = src_hits_rd(id_rs1_idx, id_rs1_ren, id_ex_rd_idx)
                    || src_hits_rd(id_rs2_idx, id_rs2_ren, id_ex_rd_idx);

    assign lu_hazard = w_load_writes_rd && w_src_hit;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Central pipeline sequencer for the 5-stage core. Produces
//                write enables and bubble flushes for the PC and all pipeline
//                registers, resolving traps, multi-cycle data-bus accesses,
//                branch redirects and load-use hazards.
//                Optional feature macro: PIPE_CTRL_PERF_EN adds the
//                stall_cnt / flush_cnt performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TO_W    = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REG_IDX_WIDTH-1:0] id_rs1_idx,
    input  logic                     id_rs1_ren,
    input  logic [REG_IDX_WIDTH-1:0] id_rs2_idx,
    input  logic                     id_rs2_ren,
    input  logic [REG_IDX_WIDTH-1:0] id_ex_rd_idx,
    input  logic                     id_ex_rd_en,
    input  logic                     id_ex_is_load,
    input  logic                     ex_br_taken,
    input  logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    input  logic                     mem_rsp_valid,
    input  logic                     mem_excp,
    output logic                     pc_wen,
    output logic                     if_id_wen,
    output logic                     id_ex_wen,
    output logic                     ex_mem_wen,
    output logic                     mem_wb_wen,
    output logic                     if_id_flush,
    output logic                     id_ex_flush,
    output logic                     ex_mem_flush,
    output logic                     mem_wb_flush,
    output logic                     trap_redirect,
    output logic                     mem_timeout,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]              stall_cnt,
    output logic [31:0]              flush_cnt,
`endif
    output logic [PIPE_ST_WIDTH-1:0] ctrl_state
);

    // Last counter value before a bus access is declared timed out
    localparam logic [MEM_TO_W-1:0] c_TO_LAST = MEM_TO_W'(MEM_TIMEOUT - 1);

    pipe_st_e              r_state;
    pipe_st_e              w_state_nxt;
    logic [MEM_TO_W-1:0]   r_to_cnt;
    logic [MEM_TO_W-1:0]   w_to_cnt_nxt;
    logic                  r_trap_redirect;
    logic                  r_mem_timeout;
    logic                  w_timeout_fire;
    logic                  w_lu_hazard;
    pipe_wen_t             w_wen;
    pipe_flush_t           w_flush;

    pipe_hazard_det u_hazard (
        .id_rs1_idx    (id_rs1_idx),
        .id_rs1_ren    (id_rs1_ren),
        .id_rs2_idx    (id_rs2_idx),
        .id_rs2_ren    (id_rs2_ren),
        .id_ex_rd_idx  (id_ex_rd_idx),
        .id_ex_rd_en   (id_ex_rd_en),
        .id_ex_is_load (id_ex_is_load),
        .lu_hazard     (w_lu_hazard)
    );

    // Next-state and raw enable/flush decode, highest-priority cause first
    always_comb begin
        w_state_nxt    = r_state;
        w_to_cnt_nxt   = '0;
        w_timeout_fire = 1'b0;
        w_wen          = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1};
        w_flush        = '0;

        case (r_state)
            PIPE_ST_RUN: begin
                if (mem_excp) begin
                    // Trapping instruction and everything younger is squashed
                    w_flush     = '1;
                    w_wen.pc    = 1'b0;
                    w_state_nxt = PIPE_ST_TRAP;
                end else if (mem_req_valid && !mem_rsp_valid) begin
                    // Hold everything up to MEM; feed a bubble into WB
                    w_wen.pc       = 1'b0;
                    w_wen.if_id    = 1'b0;
                    w_wen.id_ex    = 1'b0;
                    w_wen.ex_mem   = 1'b0;
                    w_flush.mem_wb = 1'b1;
                    if (mem_req_ready) begin
                        w_state_nxt = PIPE_ST_MEM_WAIT;
                    end
                end else if (ex_br_taken) begin
                    // Redirect wins over load-use: the dependent instruction is squashed anyway
                    w_flush.if_id = 1'b1;
                    w_flush.id_ex = 1'b1;
                end else if (w_lu_hazard) begin
                    // Hold PC/IF-ID, inject one bubble into EX
                    w_wen.pc      = 1'b0;
                    w_wen.if_id   = 1'b0;
                    w_flush.id_ex = 1'b1;
                end
            end

            PIPE_ST_MEM_WAIT: begin
                // Exceptions are not sampled here; the access must finish or time out
                if (mem_rsp_valid) begin
                    w_state_nxt = PIPE_ST_RUN;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_flush        = '1;
                    w_wen.pc       = 1'b0;
                    w_timeout_fire = 1'b1;
                    w_state_nxt    = PIPE_ST_TRAP;
                end else begin
                    w_wen.pc       = 1'b0;
                    w_wen.if_id    = 1'b0;
                    w_wen.id_ex    = 1'b0;
                    w_wen.ex_mem   = 1'b0;
                    w_flush.mem_wb = 1'b1;
                    w_to_cnt_nxt   = r_to_cnt + 1'b1;
                end
            end

            PIPE_ST_TRAP: begin
                // PC takes the trap vector; squash the wrong-path fetches
                w_flush.if_id = 1'b1;
                w_flush.id_ex = 1'b1;
                w_state_nxt   = PIPE_ST_RUN;
            end

            default: begin
                w_state_nxt = PIPE_ST_RUN;
            end
        endcase
    end

    // State, timeout counter and registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= PIPE_ST_RUN;
            r_to_cnt        <= '0;
            r_trap_redirect <= 1'b0;
            r_mem_timeout   <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_to_cnt        <= w_to_cnt_nxt;
            r_trap_redirect <= (w_state_nxt == PIPE_ST_TRAP);
            r_mem_timeout   <= w_timeout_fire;
        end
    end

    // Flush overrides wen on the same register; everything is quiet in reset
    assign pc_wen       = rst_n & w_wen.pc;
    assign if_id_wen    = rst_n & w_wen.if_id  & ~w_flush.if_id;
    assign id_ex_wen    = rst_n & w_wen.id_ex  & ~w_flush.id_ex;
    assign ex_mem_wen   = rst_n & w_wen.ex_mem & ~w_flush.ex_mem;
    assign mem_wb_wen   = rst_n & w_wen.mem_wb & ~w_flush.mem_wb;
    assign if_id_flush  = rst_n & w_flush.if_id;
    assign id_ex_flush  = rst_n & w_flush.id_ex;
    assign ex_mem_flush = rst_n & w_flush.ex_mem;
    assign mem_wb_flush = rst_n & w_flush.mem_wb;

    assign trap_redirect = r_trap_redirect;
    assign mem_timeout   = r_mem_timeout;
    assign ctrl_state    = r_state;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Free-running, wrapping stall and front-end flush counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_wen) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (if_id_flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl (MEM_TIMEOUT = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1_idx, id_rs2_idx, id_ex_rd_idx;
    logic       id_rs1_ren, id_rs2_ren, id_ex_rd_en, id_ex_is_load;
    logic       ex_br_taken, mem_req_valid, mem_req_ready, mem_rsp_valid, mem_excp;
    logic       pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic       trap_redirect, mem_timeout;
    logic [1:0] ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    pipe_ctrl #(.MEM_TO_W(8), .MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs1_idx    (id_rs1_idx),
        .id_rs1_ren    (id_rs1_ren),
        .id_rs2_idx    (id_rs2_idx),
        .id_rs2_ren    (id_rs2_ren),
        .id_ex_rd_idx  (id_ex_rd_idx),
        .id_ex_rd_en   (id_ex_rd_en),
        .id_ex_is_load (id_ex_is_load),
        .ex_br_taken   (ex_br_taken),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_excp      (mem_excp),
        .pc_wen        (pc_wen),
        .if_id_wen     (if_id_wen),
        .id_ex_wen     (id_ex_wen),
        .ex_mem_wen    (ex_mem_wen),
        .mem_wb_wen    (mem_wb_wen),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_flush  (ex_mem_flush),
        .mem_wb_flush  (mem_wb_flush),
        .trap_redirect (trap_redirect),
        .mem_timeout   (mem_timeout),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
`endif
        .ctrl_state    (ctrl_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc, if_id, id_ex, ex_mem, mem_wb wen, if_id, id_ex, ex_mem, mem_wb flush}
    function automatic logic [8:0] ctl_vec();
        return {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    endfunction

    localparam logic [8:0] V_RUN    = 9'b11111_0000;
    localparam logic [8:0] V_LU     = 9'b00011_0100;
    localparam logic [8:0] V_BR     = 9'b10011_1100;
    localparam logic [8:0] V_STALL  = 9'b00000_0001;
    localparam logic [8:0] V_TRAPIN = 9'b00000_1111;
    localparam logic [8:0] V_QUIET  = 9'b00000_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs1_idx = '0; id_rs1_ren = 0; id_rs2_idx = '0; id_rs2_ren = 0;
        id_ex_rd_idx = '0; id_ex_rd_en = 0; id_ex_is_load = 0;
        ex_br_taken = 0; mem_req_valid = 0; mem_req_ready = 0;
        mem_rsp_valid = 0; mem_excp = 0;
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      name;
        logic [4:0] rs1;  logic rs1_en;
        logic [4:0] rs2;  logic rs2_en;
        logic [4:0] rd;   logic rd_en;  logic ld;
        logic       br;   logic req;    logic rdy;  logic rsp;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{"idle",         0,0, 0,0, 0,0,0, 0,0,0,0, V_RUN};
        vecs[1]  = '{"lu_rs1_x5",    5,1, 0,0, 5,1,1, 0,0,0,0, V_LU};
        vecs[2]  = '{"lu_rs2_x5",    0,0, 5,1, 5,1,1, 0,0,0,0, V_LU};
        vecs[3]  = '{"rs1_not_read", 5,0, 0,0, 5,1,1, 0,0,0,0, V_RUN};
        vecs[4]  = '{"load_x0",      0,1, 0,1, 0,1,1, 0,0,0,0, V_RUN};
        vecs[5]  = '{"not_load",     5,1, 0,0, 5,1,0, 0,0,0,0, V_RUN};
        vecs[6]  = '{"load_no_rd",   5,1, 0,0, 5,0,1, 0,0,0,0, V_RUN};
        vecs[7]  = '{"idx_mismatch", 6,1, 7,1, 5,1,1, 0,0,0,0, V_RUN};
        vecs[8]  = '{"br_over_lu",   5,1, 0,0, 5,1,1, 1,0,0,0, V_BR};
        vecs[9]  = '{"req_not_rdy",  0,0, 0,0, 0,0,0, 0,1,0,0, V_STALL};
        vecs[10] = '{"req_rsp_same", 0,0, 0,0, 0,0,0, 0,1,1,1, V_RUN};
        vecs[11] = '{"rsp_then_lu",  5,1, 0,0, 5,1,1, 0,1,1,1, V_LU};
        vecs[12] = '{"stall_over_br",0,0, 0,0, 0,0,0, 1,1,0,0, V_STALL};

        idle_inputs();
        rst_n = 1'b0;

        // Reset state
        #3;
        check("rst_ctl", 32'(ctl_vec()), 32'(V_QUIET));
        check("rst_state", 32'(ctrl_state), 32'd0);
        check("rst_pulses", {30'd0, trap_redirect, mem_timeout}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single-cycle RUN decode table; none of these leave RUN
        for (int i = 0; i < 13; i++) begin
            id_rs1_idx = vecs[i].rs1; id_rs1_ren = vecs[i].rs1_en;
            id_rs2_idx = vecs[i].rs2; id_rs2_ren = vecs[i].rs2_en;
            id_ex_rd_idx = vecs[i].rd; id_ex_rd_en = vecs[i].rd_en;
            id_ex_is_load = vecs[i].ld; ex_br_taken = vecs[i].br;
            mem_req_valid = vecs[i].req; mem_req_ready = vecs[i].rdy;
            mem_rsp_valid = vecs[i].rsp;
            #3;
            check(vecs[i].name, 32'(ctl_vec()), 32'(vecs[i].exp));
            tick();
            check({vecs[i].name, "_state"}, 32'(ctrl_state), 32'd0);
            idle_inputs();
        end

        // Load-use: bubble now in EX, so exactly one stall cycle
        id_ex_rd_idx = 5; id_ex_rd_en = 1; id_ex_is_load = 1; id_rs1_idx = 5; id_rs1_ren = 1;
        #3; check("lu_seq_bubble", 32'(ctl_vec()), 32'(V_LU));
        tick();
        id_ex_rd_en = 0; id_ex_is_load = 0; id_ex_rd_idx = 0;
        #3; check("lu_seq_after", 32'(ctl_vec()), 32'(V_RUN));
        tick();
        idle_inputs();

        // Bus access: 3 wait cycles, response on the timeout-boundary cycle
        mem_req_valid = 1; mem_req_ready = 1;
        #3; check("mw_req", 32'(ctl_vec()), 32'(V_STALL));
        tick();
        for (int c = 0; c < 3; c++) begin
            mem_excp = (c == 1);
            #3;
            check("mw_wait", 32'(ctl_vec()), 32'(V_STALL));
            check("mw_wait_state", 32'(ctrl_state), 32'd1);
            tick();
        end
        mem_excp = 0; mem_rsp_valid = 1;
        #3; check("mw_rsp", 32'(ctl_vec()), 32'(V_RUN));
        tick();
        idle_inputs();
        check("mw_done_state", 32'(ctrl_state), 32'd0);
        check("mw_done_pulses", {30'd0, trap_redirect, mem_timeout}, 32'd0);
        tick();

        // Bus timeout after MEM_TIMEOUT cycles in MEM_WAIT
        begin
            int pulses = 0;
            mem_req_valid = 1; mem_req_ready = 1;
            tick();
            for (int c = 0; c < 3; c++) begin
                pulses += int'(mem_timeout);
                #3; check("to_wait", 32'(ctl_vec()), 32'(V_STALL));
                tick();
            end
            pulses += int'(mem_timeout);
            #3; check("to_fire", 32'(ctl_vec()), 32'(V_TRAPIN));
            tick();
            idle_inputs();
            pulses += int'(mem_timeout);
            check("to_trap_state", 32'(ctrl_state), 32'd2);
            check("to_trap_pulses", {30'd0, trap_redirect, mem_timeout}, 32'd3);
            #3; check("to_trap_ctl", 32'(ctl_vec()), 32'(V_BR));
            tick();
            pulses += int'(mem_timeout);
            check("to_back_state", 32'(ctrl_state), 32'd0);
            check("to_back_redirect", 32'(trap_redirect), 32'd0);
            tick();
            pulses += int'(mem_timeout);
            check("to_pulse_count", pulses, 32'd1);
        end

        // Exception together with a branch: trap wins
        mem_excp = 1; ex_br_taken = 1;
        #3; check("excp_br", 32'(ctl_vec()), 32'(V_TRAPIN));
        tick();
        idle_inputs();
        check("excp_trap_state", 32'(ctrl_state), 32'd2);
        check("excp_redirect", 32'(trap_redirect), 32'd1);
        check("excp_no_timeout", 32'(mem_timeout), 32'd0);
        #3; check("excp_trap_ctl", 32'(ctl_vec()), 32'(V_BR));
        tick();
        check("excp_back_state", 32'(ctrl_state), 32'd0);
        #3; check("excp_back_ctl", 32'(ctl_vec()), 32'(V_RUN));
        tick();

`ifdef PIPE_CTRL_PERF_EN
        // Counters after one reset: fresh start, one stall, one branch flush
        rst_n = 0; #2; rst_n = 1;
        tick();
        mem_req_valid = 1; tick();
        idle_inputs(); ex_br_taken = 1; tick();
        idle_inputs();
        check("perf_stall", stall_cnt, 32'd1);
        check("perf_flush", flush_cnt, 32'd1);
`endif

        // Asynchronous reset in the middle of MEM_WAIT
        mem_req_valid = 1; mem_req_ready = 1;
        tick();
        check("arst_pre_state", 32'(ctrl_state), 32'd1);
        rst_n = 0;
        #1;
        check("arst_state", 32'(ctrl_state), 32'd0);
        check("arst_pulses", {30'd0, trap_redirect, mem_timeout}, 32'd0);
        check("arst_ctl", 32'(ctl_vec()), 32'(V_QUIET));
`ifdef PIPE_CTRL_PERF_EN
        check("arst_stall_cnt", stall_cnt, 32'd0);
        check("arst_flush_cnt", flush_cnt, 32'd0);
`endif
        idle_inputs();
        tick();
        rst_n = 1;
        tick();
        check("arst_after_state", 32'(ctrl_state), 32'd0);
        #2; check("arst_after_ctl", 32'(ctl_vec()), 32'(V_RUN));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
